// File: rtl/gsplat_pkg.sv
// gsplat_pkg: constants shared by the DDRAM arbiter, the splat fetch engine
// and the tile framebuffer writeback engine.
//   DDR_ADDR_W / DDR_DATA_W / DDR_BE_W : DDRAM Avalon-MM port geometry
//   BURST_MAX                          : largest legal burst in 64-bit beats
//   ST_*                               : arbiter state encodings
package gsplat_pkg;

    localparam int DDR_ADDR_W = 29;
    localparam int DDR_DATA_W = 64;
    localparam int DDR_BE_W   = 8;
    localparam int BURST_MAX  = 128;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD_CMD   = 2'd1;
    localparam logic [1:0] ST_RD_DATA  = 2'd2;
    localparam logic [1:0] ST_WR_BURST = 2'd3;

endpackage

// File: rtl/gsplat_ddr_arbiter_if.sv
// gsplat_ddr_arbiter_if: the single DDRAM Avalon-MM port.
//   master modport : arbiter side (drives command/write data, sees waitrequest
//                    and returned read data)
//   slave modport  : memory side
interface gsplat_ddr_arbiter_if;

    logic                              ddram_busy;
    logic [7:0]                        ddram_burstcnt;
    logic [gsplat_pkg::DDR_ADDR_W-1:0] ddram_addr;
    logic                              ddram_rd;
    logic                              ddram_we;
    logic [gsplat_pkg::DDR_DATA_W-1:0] ddram_din;
    logic [gsplat_pkg::DDR_BE_W-1:0]   ddram_be;
    logic [gsplat_pkg::DDR_DATA_W-1:0] ddram_dout;
    logic                              ddram_dout_ready;

    modport master (
        input  ddram_busy, ddram_dout, ddram_dout_ready,
        output ddram_burstcnt, ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be
    );

    modport slave (
        output ddram_busy, ddram_dout, ddram_dout_ready,
        input  ddram_burstcnt, ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be
    );

endinterface

// File: rtl/gsplat_ddr_arbiter.sv
// gsplat_ddr_arbiter: burst-level round-robin arbiter between the splat fetch
// engine (reads) and the tile writeback engine (writes) on one DDRAM port.
//   clk, reset_n        : system clock, synchronous active-low reset
//   rd_req/addr/len     : read burst request; rd_gnt pulses on command accept
//   rd_data/valid/done  : registered read beats, rd_done on the last one
//   wr_req/addr/len     : write burst request (burst fully buffered)
//   wr_data/be          : current write beat; wr_ack consumes it
//   wr_done             : pulses with the last wr_ack
//   ddram               : DDRAM Avalon-MM master port
//   busy                : arbiter not idle
//   err_stray           : sticky, read beat seen with no read outstanding
module gsplat_ddr_arbiter
    import gsplat_pkg::*;
#(
    parameter int BURST_MAX = gsplat_pkg::BURST_MAX
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  rd_req,
    input  logic [DDR_ADDR_W-1:0] rd_addr,
    input  logic [7:0]            rd_len,
    output logic                  rd_gnt,
    output logic [DDR_DATA_W-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_done,

    input  logic                  wr_req,
    input  logic [DDR_ADDR_W-1:0] wr_addr,
    input  logic [7:0]            wr_len,
    input  logic [DDR_DATA_W-1:0] wr_data,
    input  logic [DDR_BE_W-1:0]   wr_be,
    output logic                  wr_ack,
    output logic                  wr_done,

    gsplat_ddr_arbiter_if.master  ddram,

    output logic                  busy,
    output logic                  err_stray
);

    logic [1:0] state;
    logic       last_wr;
    logic [7:0] beat_cnt;
    logic       pick_rd;
    logic       pick_wr;

    // 0 becomes 1, anything above BURST_MAX is clamped
    function automatic logic [7:0] norm_len(input logic [7:0] len);
        if (len == 8'd0)
            return 8'd1;
        else if ({24'd0, len} > 32'(BURST_MAX))
            return 8'(BURST_MAX);
        else
            return len;
    endfunction

    // On a tie the requester not served last wins
    always_comb begin
        pick_rd = rd_req && (!wr_req || last_wr);
        pick_wr = wr_req && !pick_rd;
    end

    always_comb begin
        busy           = (state != ST_IDLE);
        ddram.ddram_rd = (state == ST_RD_CMD);
        ddram.ddram_we = (state == ST_WR_BURST);
        ddram.ddram_din = ddram.ddram_we ? wr_data : '0;
        ddram.ddram_be  = ddram.ddram_we ? wr_be   : '0;
        rd_gnt  = ddram.ddram_rd && !ddram.ddram_busy;
        wr_ack  = ddram.ddram_we && !ddram.ddram_busy;
        wr_done = wr_ack && (beat_cnt == 8'd1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                <= ST_IDLE;
            last_wr              <= 1'b1;
            beat_cnt             <= '0;
            rd_data              <= '0;
            rd_valid             <= 1'b0;
            rd_done              <= 1'b0;
            err_stray            <= 1'b0;
            ddram.ddram_addr     <= '0;
            ddram.ddram_burstcnt <= '0;
        end else begin
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;

            // beats outside RD_DATA are dropped, only flagged
            if (ddram.ddram_dout_ready && state != ST_RD_DATA)
                err_stray <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (pick_rd) begin
                        ddram.ddram_addr     <= rd_addr;
                        ddram.ddram_burstcnt <= norm_len(rd_len);
                        state                <= ST_RD_CMD;
                    end else if (pick_wr) begin
                        ddram.ddram_addr     <= wr_addr;
                        ddram.ddram_burstcnt <= norm_len(wr_len);
                        beat_cnt             <= norm_len(wr_len);
                        state                <= ST_WR_BURST;
                    end
                end
                ST_RD_CMD: begin
                    if (!ddram.ddram_busy) begin
                        beat_cnt <= ddram.ddram_burstcnt;
                        state    <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (ddram.ddram_dout_ready) begin
                        rd_data  <= ddram.ddram_dout;
                        rd_valid <= 1'b1;
                        beat_cnt <= beat_cnt - 8'd1;
                        if (beat_cnt == 8'd1) begin
                            rd_done <= 1'b1;
                            last_wr <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_WR_BURST: begin
                    if (!ddram.ddram_busy) begin
                        beat_cnt <= beat_cnt - 8'd1;
                        if (beat_cnt == 8'd1) begin
                            last_wr <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsplat_ddr_arbiter.sv
// tb_gsplat_ddr_arbiter: directed self-checking bench for gsplat_ddr_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
module tb_gsplat_ddr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd_req;
    logic [28:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_gnt;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        rd_done;
    logic        wr_req;
    logic [28:0] wr_addr;
    logic [7:0]  wr_len;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        wr_ack;
    logic        wr_done;
    logic        busy;
    logic        err_stray;

    int checks = 0;
    int errors = 0;

    gsplat_ddr_arbiter_if ddr ();

    gsplat_ddr_arbiter #(.BURST_MAX(128)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .rd_gnt    (rd_gnt),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_done   (rd_done),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_len    (wr_len),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .wr_ack    (wr_ack),
        .wr_done   (wr_done),
        .ddram     (ddr),
        .busy      (busy),
        .err_stray (err_stray)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle after changing inputs
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        rd_req = 0; rd_addr = '0; rd_len = '0;
        wr_req = 0; wr_addr = '0; wr_len = '0; wr_data = '0; wr_be = '0;
        ddr.ddram_busy = 0; ddr.ddram_dout = '0; ddr.ddram_dout_ready = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        step();
        step();
        reset_n = 1;
        settle();
    endtask

    logic [63:0] rdat [4];
    logic [1:0]  busy_seq [5];
    logic [63:0] wdat [3];
    int          k;
    int          acks;
    logic        done_seen;
    logic        pend;
    int          both_high;
    logic [7:0]  order [4];
    int          n_ev;

    initial begin
        idle_inputs();
        rdat = '{64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD,
                 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        wdat = '{64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0003};
        busy_seq = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0};

        // ---------------- reset state ----------------
        step();
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_rd", ddr.ddram_rd, 0);
        chk("rst_we", ddr.ddram_we, 0);
        chk("rst_addr", ddr.ddram_addr, 0);
        chk("rst_burstcnt", ddr.ddram_burstcnt, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_err", err_stray, 0);

        // ---------------- single read, len 4 ----------------
        step();
        rd_req = 1; rd_addr = 29'h100; rd_len = 8'd4;
        settle();
        chk("rd_idle_gnt", rd_gnt, 0);
        step();
        rd_req = 0;
        settle();
        chk("rd_gnt", rd_gnt, 1);
        chk("rd_cmd_rd", ddr.ddram_rd, 1);
        chk("rd_cmd_addr", ddr.ddram_addr, 64'h100);
        chk("rd_cmd_cnt", ddr.ddram_burstcnt, 4);
        for (int i = 0; i < 4; i++) begin
            step();
            ddr.ddram_dout_ready = 1; ddr.ddram_dout = rdat[i];
            settle();
            chk("rd_data_rd_low", ddr.ddram_rd, 0);
            chk("rd_valid", rd_valid, (i > 0) ? 1 : 0);
            if (i > 0) chk("rd_beat", rd_data, rdat[i-1]);
            chk("rd_done_early", rd_done, 0);
        end
        step();
        ddr.ddram_dout_ready = 0;
        settle();
        chk("rd_last_valid", rd_valid, 1);
        chk("rd_last_beat", rd_data, rdat[3]);
        chk("rd_done", rd_done, 1);
        chk("rd_busy_after", busy, 0);
        step();
        chk("rd_valid_after", rd_valid, 0);
        chk("rd_stray_none", err_stray, 0);

        // ---------------- write len 3 under waitrequest ----------------
        wr_req = 1; wr_addr = 29'h0600_0000; wr_len = 8'd3; wr_be = 8'hFF;
        wr_data = wdat[0];
        settle();
        k = 0; acks = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            wr_req = 0;
            ddr.ddram_busy = busy_seq[c][0];
            wr_data = wdat[k];
            settle();
            chk("wr_we", ddr.ddram_we, 1);
            chk("wr_rd_low", ddr.ddram_rd, 0);
            chk("wr_ack", wr_ack, busy_seq[c][0] ? 0 : 1);
            chk("wr_din", ddr.ddram_din, wdat[k]);
            chk("wr_be", ddr.ddram_be, 8'hFF);
            chk("wr_addr", ddr.ddram_addr, 64'h0600_0000);
            chk("wr_cnt", ddr.ddram_burstcnt, 3);
            chk("wr_done", wr_done, (!busy_seq[c][0] && k == 2) ? 1 : 0);
            if (wr_ack) begin
                acks++;
                if (k < 2) k++;
            end
        end
        chk("wr_acks", acks, 3);
        step();
        ddr.ddram_busy = 0;
        settle();
        chk("wr_busy_after", busy, 0);
        chk("wr_we_after", ddr.ddram_we, 0);

        // ---------------- simultaneous requests out of reset ----------------
        do_reset();
        rd_req = 1; rd_addr = 29'h40; rd_len = 8'd1;
        wr_req = 1; wr_addr = 29'h80; wr_len = 8'd1;
        pend = 0; both_high = 0; n_ev = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            ddr.ddram_dout_ready = pend;
            ddr.ddram_dout = 64'h55;
            settle();
            if (ddr.ddram_rd && ddr.ddram_we) both_high++;
            if (rd_gnt && n_ev < 4) begin order[n_ev] = "R"; n_ev++; end
            if (wr_done && n_ev < 4) begin order[n_ev] = "W"; n_ev++; end
            pend = rd_gnt;
        end
        rd_req = 0; wr_req = 0; ddr.ddram_dout_ready = 0;
        chk("rr_events", n_ev, 4);
        chk("rr_0", order[0], "R");
        chk("rr_1", order[1], "W");
        chk("rr_2", order[2], "R");
        chk("rr_3", order[3], "W");
        chk("rr_rd_we_overlap", both_high, 0);
        chk("rr_stray", err_stray, 0);
        step(); step(); step();

        // ---------------- length boundaries ----------------
        settle();
        chk("len_idle", busy, 0);
        rd_req = 1; rd_addr = 29'h200; rd_len = 8'd0;
        step();
        rd_req = 0;
        settle();
        chk("len0_cnt", ddr.ddram_burstcnt, 1);
        chk("len0_gnt", rd_gnt, 1);
        step();
        ddr.ddram_dout_ready = 1; ddr.ddram_dout = 64'h77;
        step();
        ddr.ddram_dout_ready = 0;
        settle();
        chk("len0_done", rd_done, 1);
        chk("len0_data", rd_data, 64'h77);
        chk("len0_busy", busy, 0);

        step();
        wr_req = 1; wr_addr = 29'h300; wr_len = 8'd200; wr_data = 64'h9;
        acks = 0; done_seen = 0;
        for (int c = 0; c < 140 && !done_seen; c++) begin
            step();
            wr_req = 0;
            settle();
            if (c == 0) chk("len200_cnt", ddr.ddram_burstcnt, 128);
            if (wr_ack) acks++;
            if (wr_done) begin
                done_seen = 1;
                chk("len200_done_at", acks, 128);
            end
        end
        chk("len200_done_seen", done_seen, 1);
        chk("len200_acks", acks, 128);
        step();
        settle();
        chk("len200_idle", busy, 0);

        // ---------------- stray beat ----------------
        ddr.ddram_dout_ready = 1; ddr.ddram_dout = 64'hBAD;
        step();
        ddr.ddram_dout_ready = 0;
        settle();
        chk("stray_set", err_stray, 1);
        chk("stray_no_valid", rd_valid, 0);
        step(); step(); step();
        chk("stray_sticky", err_stray, 1);
        do_reset();
        chk("stray_cleared", err_stray, 0);

        // ---------------- reset mid RD_DATA ----------------
        step();
        rd_req = 1; rd_addr = 29'h500; rd_len = 8'd8;
        step();
        rd_req = 0;
        settle();
        chk("mid_gnt", rd_gnt, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            ddr.ddram_dout_ready = 1; ddr.ddram_dout = 64'hC0 + 64'(i);
        end
        step();
        ddr.ddram_dout_ready = 0;
        reset_n = 0;
        settle();
        chk("mid_valid_before", rd_valid, 1);
        step();
        reset_n = 1;
        settle();
        chk("mid_busy", busy, 0);
        chk("mid_rd_valid", rd_valid, 0);
        chk("mid_rd_done", rd_done, 0);
        chk("mid_rd_data", rd_data, 0);
        chk("mid_ddram_rd", ddr.ddram_rd, 0);
        chk("mid_addr", ddr.ddram_addr, 0);
        chk("mid_cnt", ddr.ddram_burstcnt, 0);
        wr_req = 1; wr_addr = 29'h600; wr_len = 8'd2; wr_data = 64'hE1;
        step();
        wr_req = 0;
        settle();
        chk("post_we", ddr.ddram_we, 1);
        chk("post_addr", ddr.ddram_addr, 64'h600);
        chk("post_ack1", wr_ack, 1);
        chk("post_done1", wr_done, 0);
        step();
        wr_data = 64'hE2;
        settle();
        chk("post_ack2", wr_ack, 1);
        chk("post_done2", wr_done, 1);
        step();
        chk("post_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gsplat_ddr_arbiter.md
# gsplat_ddr_arbiter

Burst-level arbiter sharing the single DDRAM Avalon-MM port between the splat fetch engine (reads of projected splat records written by the HPS) and the tile framebuffer writeback engine (writes into the 640x480x32bpp framebuffer at 0x30000000). It sits inside gsplat_top, directly in front of the ddram_* ports. It grants one whole burst at a time, round-robin between the two requesters. It tracks outstanding read beats so a new burst is never issued while read data is still returning.

## Interface
Parameters:
- BURST_MAX, 128: largest legal burst length in 64-bit beats.

Ports:
- clk  in  1  system clock (clk_sys); the DDRAM clock is driven from the same net.
- reset_n  in  1  synchronous, active-low reset.
- rd_req  in  1  fetch engine requests a read burst; holds until rd_gnt.
- rd_addr  in  29  64-bit word address of the read burst.
- rd_len  in  8  read beats requested.
- rd_gnt  out  1  one-cycle pulse; the read command has been accepted by DDRAM.
- rd_data  out  64  returned read beat, registered.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_done  out  1  one-cycle pulse, coincident with the last rd_valid of the burst.
- wr_req  in  1  writeback engine requests a write burst; the whole burst must already be buffered.
- wr_addr  in  29  64-bit word address of the write burst.
- wr_len  in  8  write beats.
- wr_data  in  64  current write beat.
- wr_be  in  8  byte enables for the current beat.
- wr_ack  out  1  current beat consumed this cycle; the writer presents the next beat on the following cycle.
- wr_done  out  1  one-cycle pulse, coincident with the last wr_ack.
- ddram_busy  in  1  Avalon waitrequest.
- ddram_burstcnt  out  8
- ddram_addr  out  29
- ddram_rd  out  1
- ddram_we  out  1
- ddram_din  out  64
- ddram_be  out  8
- ddram_dout  in  64
- ddram_dout_ready  in  1
- busy  out  1  arbiter not in IDLE.
- err_stray  out  1  sticky flag: a read beat arrived while no read was outstanding.

## Operation
- States: IDLE, RD_CMD, RD_DATA, WR_BURST.
- **Length normalisation.** The length is latched at grant.
  - 0 is treated as 1.
  - Values above BURST_MAX are clamped to BURST_MAX.
- **IDLE.**
  - If only one request is present, that requester is granted.
  - If both are present, the requester not served last is granted. last_wr resets to 1, so reads win the first tie.
  - When the next state is RD_CMD, the arbiter latches address and length into ddram_addr/ddram_burstcnt.
  - When the next state is WR_BURST, it latches address and length into ddram_addr/ddram_burstcnt and the beat counter.
- **RD_CMD.**
  - ddram_rd=1 and is held until a cycle with ddram_busy=0.
  - In that cycle: pulse rd_gnt, load beat counter = len, go to RD_DATA.
- **RD_DATA.**
  - Each ddram_dout_ready registers ddram_dout into rd_data, with rd_valid one cycle later, and decrements the counter.
  - When the counter reaches 0: rd_done pulses with the final rd_valid, set last_wr=0, go to IDLE.
- **WR_BURST.**
  - ddram_we=1; ddram_din=wr_data and ddram_be=wr_be pass through combinationally.
  - wr_ack = ddram_busy==0.
  - Each ack decrements the counter. On the last ack: wr_done pulses, set last_wr=1, go to IDLE.
  - ddram_addr and ddram_burstcnt are held for the whole burst.
- **Stray beats.** ddram_dout_ready outside RD_DATA is dropped and sets err_stray. err_stray is cleared only by reset.
- **Requests outside IDLE.** Requests are ignored outside IDLE. A requester changing address or length while waiting has no effect until it is granted.
- **Reset.**
  - All outputs go to 0, state=IDLE, last_wr=1, counters=0.
  - Reset mid-burst abandons the burst; the system resets only when DDRAM is quiescent.

## Timing
- Request in IDLE at cycle N puts ddram_rd or ddram_we on the bus at N+1. This is the grant latency.
- Read with zero wait states: rd_gnt at N+1; first rd_valid 1 cycle after the first ddram_dout_ready.
- Write with zero wait states: L beats occupy cycles N+1 .. N+L; wr_done at N+L; IDLE at N+L+1.
- There is one dead IDLE cycle between consecutive bursts.
- ddram_rd/ddram_we are never both high. Neither is high in IDLE or RD_DATA.
- Worst-case wait for a requester is one full burst of the other requester.

## Structure
- Package gsplat_pkg holds:
  - DDR_ADDR_W=29, DDR_DATA_W=64, DDR_BE_W=8, BURST_MAX=128;
  - the arbiter state enum.
- The package is shared with the fetch and writeback engines.
- Single module; no sub-module is natural. Round-robin select and beat counter are inline.

## Test plan
- **Single read.** rd_req, addr 0x100, len 4, busy=0, 4 beats returned on consecutive cycles.
  - Required: rd_gnt 1 cycle after the request; four rd_valid with matching data; rd_done on the 4th; busy low afterwards.
- **Single write under waitrequest.** wr_req, len 3, busy toggling 1,0,1,0,0.
  - Required: exactly 3 wr_ack, only on busy=0 cycles; addr/burstcnt stable throughout; wr_done on the 3rd ack.
- **Simultaneous requests out of reset.** Both requests held continuously.
  - Required: grant order read, write, read, write.
  - ddram_rd and ddram_we are never high together.
- **Length boundaries.** rd_len=0 -> burstcnt=1 and one beat. wr_len=200 -> burstcnt=128 and 128 acks.
- **Stray beat.** ddram_dout_ready pulse while IDLE.
  - Required: err_stray=1 and stays set; no rd_valid.
  - Reset then clears err_stray.
- **Reset mid-RD_DATA.** reset_n low after 2 of 8 beats.
  - Required: all outputs 0 the next cycle; state IDLE; a subsequent wr_req is served normally.
